vblank_scheduler: RTL
=====================

# vblank_scheduler

- Sequences per-frame game-state updates into the vertical blanking interval so sprite positions never change mid-scan.
- Watches the VGA line/pixel counters and opens an update window at the start of vertical blank.
- Grants the window, one requester at a time and in fixed priority order, to the entity update engines: Pac-Man, the four ghosts, score and bonus.
- Sits between the VGA controller counters and the entity logic; the pixel mux sees only stable positions.

## Interface
Parameters:
- N_REQ, 7 — number of requesters; index 0 = Pac-Man, 1–4 = Blinky/Pinky/Inky/Clyde, 5 = score, 6 = bonus.
- V_ACTIVE_LAST, 767 — last visible `v_counter` value.
- SLOT_MAX, 255 — watchdog limit in cycles per grant.

Ports:
- clk  in  1  pixel clock, 75 MHz.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- v_counter  in  10  screen vertical counter.
- h_counter  in  11  screen horizontal counter.
- req  in  N_REQ  update request, level, one per requester.
- done  in  N_REQ  update complete, one per requester.
- ovr_clr  in  1  clears `overrun`.
- grant  out  N_REQ  one-hot update grant.
- frame_tick  out  1  one-cycle pulse at window open.
- busy  out  1  high while the FSM is not in IDLE.
- overrun  out  1  sticky: a window closed with work still pending.
- timeout  out  N_REQ  sticky per-requester watchdog flags.
- frame_cnt  out  8  frame counter.

## Operation
- **Open event:** `v_counter == V_ACTIVE_LAST+1` and `h_counter == 0`.
- **Close event:** `v_counter == 0` and `h_counter == 0`.
- **FSM states:** IDLE, SCAN, GRANT, GAP.
- **IDLE:**
  - On the open event: `pend <= req`, `frame_tick <= 1`, `frame_cnt <= frame_cnt+1` (8-bit, wraps 255→0), go to SCAN.
  - Requests asserted after the latch wait for the next frame.
- **SCAN:**
  - If `pend` is nonzero, set `grant[k]` for the lowest set index k and go to GRANT.
  - Otherwise go to IDLE.
- **GRANT:**
  - On `done[k]` with `grant[k]` high: clear `grant` and `pend[k]`, go to GAP.
  - `done` on a non-granted index is ignored.
- **GAP:** one cycle, then SCAN.
- **Close event in any non-IDLE state:**
  - Clear `grant`.
  - If `pend` (after any same-cycle `done` is applied) is nonzero, set `overrun`.
  - Clear `pend`; go to IDLE.
- **Simultaneous events:**
  - `done` and close in the same cycle: `done` is honoured first.
  - `ovr_clr` and an `overrun` set in the same cycle: set wins.
- **Overlapping frames:** an open event while not in IDLE is impossible by counter geometry and needs no handling.
- **Reset values:** `grant=0`, `frame_tick=0`, `busy=0`, `overrun=0`, `timeout=0`, `frame_cnt=0`, FSM in IDLE, `pend=0`.
- **Reset mid-grant:** `grant` drops asynchronously.

## Timing
- All outputs are registered.
- Open event sampled at edge E:
  - `frame_tick` is high in cycle E+1 only.
  - First `grant` is high from E+2 (SCAN occupies E+1).
- `done` sampled at edge D: `grant` is low from D+1; the next grant rises at D+3 (GAP at D+1, SCAN at D+2).
- Grant-to-grant gap is 2 low cycles.
- `busy` is high from E+1 until the cycle after SCAN finds `pend == 0` or the close event.
- Minimum window cost with all 7 requesters granted and each `done` one cycle after its grant: 7 × 3 + 1 = 22 cycles.

## Configuration
- Macro: `VBLANK_WATCHDOG_EN`.
- **Defined:**
  - An 8-bit slot counter clears on every grant rise and counts while in GRANT.
  - On reaching SLOT_MAX without `done`: drop `grant`, set `timeout[k]`, clear `pend[k]`, go to GAP.
  - `done` and expiry in the same cycle: `done` wins, no timeout.
  - `timeout` flags clear only on reset.
- **Undefined:**
  - No counter.
  - A grant is held until `done` or the close event.
  - `timeout` is tied to 0.

## Test plan
- **Reset:** assert `reset_n=0` mid-grant → all outputs 0 within the same cycle, FSM in IDLE.
- **Full sequence:** `req=7'h7F`, each `done` one cycle after its grant → grants 0,1,…,6 in order, 2-cycle gaps, `overrun=0`, `frame_cnt` 0→1.
- **Sparse and late requests:** `req=7'b0010010` at the open event → grants only index 1 then index 4. `req[0]` rising after the open event is not granted until the next frame.
- **Overrun:** `req[3]` granted, `done` withheld, macro off → `grant[3]` drops at `v_counter=0`, `h_counter=0` and `overrun=1`. `ovr_clr` pulsed with no new overrun → `overrun=0`.
- **Watchdog (macro on):** `req=7'h03`, `done[0]` never asserted → `grant[0]` drops after 255 cycles, `timeout=7'h01`, `grant[1]` rises 2 cycles later.
- **Counter wrap:** run 256 frames → `frame_cnt` wraps 255→0, with one `frame_tick` per frame.

Source files
------------

// File: rtl/vblank_if.sv
// Bundle between the raster counters / entity engines and the vblank update scheduler.
interface vblank_if #(parameter int N_REQ = 7);
    logic [9:0]       v_counter;
    logic [10:0]      h_counter;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic             ovr_clr;
    logic [N_REQ-1:0] grant;
    logic             frame_tick;
    logic             busy;
    logic             overrun;
    logic [N_REQ-1:0] timeout;
    logic [7:0]       frame_cnt;

    modport master (
        output v_counter, h_counter, req, done, ovr_clr,
        input  grant, frame_tick, busy, overrun, timeout, frame_cnt
    );

    modport slave (
        input  v_counter, h_counter, req, done, ovr_clr,
        output grant, frame_tick, busy, overrun, timeout, frame_cnt
    );
endinterface

// File: rtl/vblank_scheduler.sv
// Hands the vertical-blank update window to entity engines one at a time, fixed priority.
// Optional per-grant watchdog enabled by defining VBLANK_WATCHDOG_EN.
module vblank_scheduler #(
    parameter int N_REQ         = 7,
    parameter int V_ACTIVE_LAST = 767,
    parameter int SLOT_MAX      = 255
) (
    input  logic    clk,
    input  logic    reset_n,
    vblank_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, GRANT, GAP} state_t;

    localparam logic [9:0] V_OPEN = 10'(V_ACTIVE_LAST + 1);

    state_t           state;
    logic [N_REQ-1:0] pend, grant, lowest, pend_after;
    logic             frame_tick, busy, overrun;
    logic [7:0]       frame_cnt;
    logic             open_ev, close_ev, done_hit, expire, rel, ovr_set;

    assign open_ev    = (bus.v_counter == V_OPEN) && (bus.h_counter == '0);
    assign close_ev   = (bus.v_counter == '0) && (bus.h_counter == '0);
    // lowest set bit of pend: index 0 has the highest priority
    assign lowest     = pend & (~pend + N_REQ'(1));
    assign done_hit   = (state == GRANT) && |(bus.done & grant);
    assign rel        = done_hit || expire;
    // a same-cycle done/expiry retires its requester before the close check
    assign pend_after = rel ? (pend & ~grant) : pend;
    assign ovr_set    = close_ev && (state != IDLE) && |pend_after;

`ifdef VBLANK_WATCHDOG_EN
    logic [7:0]       slot_cnt;
    logic [N_REQ-1:0] timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt <= '0;
            timeout  <= '0;
        end else begin
            if (state == SCAN)
                slot_cnt <= '0;
            else if (state == GRANT)
                slot_cnt <= slot_cnt + 8'd1;
            if (expire)
                timeout <= timeout | grant;
        end
    end

    assign expire      = (state == GRANT) && (slot_cnt == 8'(SLOT_MAX - 1)) && !done_hit;
    assign bus.timeout = timeout;
`else
    assign expire      = 1'b0;
    assign bus.timeout = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pend       <= '0;
            grant      <= '0;
            frame_tick <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_tick <= 1'b0;
            overrun    <= ovr_set | (overrun & ~bus.ovr_clr);
            if (close_ev && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
                grant <= '0;
                pend  <= '0;
            end else begin
                case (state)
                    IDLE: if (open_ev) begin
                        pend       <= bus.req;
                        frame_tick <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                        busy       <= 1'b1;
                        state      <= SCAN;
                    end
                    SCAN: if (|pend) begin
                        grant <= lowest;
                        state <= GRANT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    GRANT: if (rel) begin
                        grant <= '0;
                        pend  <= pend_after;
                        state <= GAP;
                    end
                    GAP: state <= SCAN;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.grant      = grant;
    assign bus.frame_tick = frame_tick;
    assign bus.busy       = busy;
    assign bus.overrun    = overrun;
    assign bus.frame_cnt  = frame_cnt;
endmodule
